// File: rtl/pontuacao_pkg.sv
// pontuacao_pkg: shared states, widths, default parameters and the double-dabble step.
package pontuacao_pkg;
    localparam int W_PONTOS = 7;
    localparam int W_BCD = 12;
    localparam int W_ERROS = 3;
    localparam int GANHO_BASE_DEF = 5;
    localparam int BONUS_FINAL_DEF = 20;
    localparam int PONTOS_MAX_DEF = 100;
    typedef enum logic [1:0] {OCIOSO = 2'd0, JOGANDO = 2'd1, ENCERRADO = 2'd2} estado_t;
    typedef enum logic {PARADO = 1'b0, CONVERTE = 1'b1} conv_t;
    // One iteration: +3 on every BCD nibble >= 5, then shift the whole {bcd, bin} left.
    function automatic logic [W_BCD+W_PONTOS-1:0] dd_passo(input logic [W_BCD+W_PONTOS-1:0] s);
        logic [W_BCD+W_PONTOS-1:0] a;
        a = s;
        for (int n = 0; n < 3; n++)
            if (a[W_PONTOS+4*n +: 4] >= 4'd5) a[W_PONTOS+4*n +: 4] = a[W_PONTOS+4*n +: 4] + 4'd3;
        return {a[W_BCD+W_PONTOS-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/pontuacao_bcd_if.sv
// pontuacao_bcd_if: outcome strobes in, score/display/status out.
interface pontuacao_bcd_if;
    import pontuacao_pkg::*;
    logic                inicia;
    logic                erro_jogada;
    logic                fim_rodada;
    logic                fim_jogo;
    logic [W_PONTOS-1:0] pontos;
    logic [W_BCD-1:0]    display;
    logic                display_valido;
    logic [1:0]          db_estado;
    modport master (output inicia, erro_jogada, fim_rodada, fim_jogo,
                    input pontos, display, display_valido, db_estado);
    modport slave  (input inicia, erro_jogada, fim_rodada, fim_jogo,
                    output pontos, display, display_valido, db_estado);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 7-iteration double-dabble; bcd only changes when a conversion completes.
module bin2bcd_seq
    import pontuacao_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                carga,
    input  logic [W_PONTOS-1:0] bin,
    output logic [W_BCD-1:0]    bcd,
    output logic                valido
);
    conv_t r_estado, w_estado_prox;
    logic [W_BCD+W_PONTOS-1:0] r_sh, w_sh_prox, w_passo;
    logic [2:0] r_cnt, w_cnt_prox;
    logic [W_BCD-1:0] r_bcd, w_bcd_prox;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= PARADO;
            r_sh <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
        end else begin
            r_estado <= w_estado_prox;
            r_sh <= w_sh_prox;
            r_cnt <= w_cnt_prox;
            r_bcd <= w_bcd_prox;
        end
    end

    always_comb begin
        w_passo = dd_passo(r_sh);
        w_estado_prox = r_estado;
        w_sh_prox = r_sh;
        w_cnt_prox = r_cnt;
        w_bcd_prox = r_bcd;
        if (carga) begin
            w_estado_prox = CONVERTE;
            w_sh_prox = {{W_BCD{1'b0}}, bin};
            w_cnt_prox = '0;
        end else if (r_estado == CONVERTE) begin
            w_sh_prox = w_passo;
            w_cnt_prox = r_cnt + 3'd1;
            if (r_cnt == 3'd6) begin
                w_estado_prox = PARADO;
                w_bcd_prox = w_passo[W_BCD+W_PONTOS-1:W_PONTOS];
            end
        end
    end

    assign bcd = r_bcd;
    assign valido = (r_estado == PARADO);
endmodule

// File: rtl/pontuacao_bcd.sv
// pontuacao_bcd: saturating game score with BCD display; end-of-game bonus under PONTOS_BONUS_EN.
module pontuacao_bcd
    import pontuacao_pkg::*;
#(
    parameter int GANHO_BASE = GANHO_BASE_DEF,
    parameter int PONTOS_MAX = PONTOS_MAX_DEF
`ifdef PONTOS_BONUS_EN
    , parameter int BONUS_FINAL = BONUS_FINAL_DEF
`endif
) (
    input logic clock,
    input logic reset,
    pontuacao_bcd_if.slave bus
);
    localparam logic [7:0] GB = 8'(GANHO_BASE);
    localparam logic [7:0] MX = 8'(PONTOS_MAX);
    estado_t r_estado, w_estado_prox;
    logic [W_PONTOS-1:0] r_pontos, w_pontos_prox;
    logic [W_ERROS-1:0] r_erros_rodada, w_erros_rodada_prox, w_erros_ef;
    logic [7:0] w_ganho, w_soma, w_sat;
    logic w_jogando, w_erro, w_carga, w_valido;
    logic [W_BCD-1:0] w_bcd;
`ifdef PONTOS_BONUS_EN
    localparam logic [7:0] BF = 8'(BONUS_FINAL);
    logic r_erros_jogo, w_erros_jogo_prox;
    logic [7:0] w_soma_b, w_sat_b;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= OCIOSO;
            r_pontos <= '0;
            r_erros_rodada <= '0;
`ifdef PONTOS_BONUS_EN
            r_erros_jogo <= 1'b0;
`endif
        end else begin
            r_estado <= w_estado_prox;
            r_pontos <= w_pontos_prox;
            r_erros_rodada <= w_erros_rodada_prox;
`ifdef PONTOS_BONUS_EN
            r_erros_jogo <= w_erros_jogo_prox;
`endif
        end
    end

    // The error of the current cycle already counts toward the gain and the bonus test.
    always_comb begin
        w_jogando = (r_estado == JOGANDO);
        w_erro = w_jogando && bus.erro_jogada;
        w_erros_ef = (w_erro && r_erros_rodada != 3'd7) ? r_erros_rodada + 3'd1 : r_erros_rodada;
        w_ganho = (8'(w_erros_ef) >= GB) ? 8'd0 : GB - 8'(w_erros_ef);
        w_soma = {1'b0, r_pontos} + ((w_jogando && bus.fim_rodada) ? w_ganho : 8'd0);
        w_sat = (w_soma > MX) ? MX : w_soma;
`ifdef PONTOS_BONUS_EN
        w_soma_b = w_sat + BF;
        w_sat_b = (w_soma_b > MX) ? MX : w_soma_b;
        w_erros_jogo_prox = r_erros_jogo | w_erro;
`endif
        w_estado_prox = r_estado;
        w_pontos_prox = r_pontos;
        w_erros_rodada_prox = w_erros_ef;
        w_carga = 1'b0;
        if (bus.inicia) begin
            w_estado_prox = JOGANDO;
            w_pontos_prox = '0;
            w_erros_rodada_prox = '0;
            w_carga = 1'b1;
`ifdef PONTOS_BONUS_EN
            w_erros_jogo_prox = 1'b0;
`endif
        end else if (w_jogando) begin
            w_pontos_prox = 7'(w_sat);
            if (bus.fim_rodada) begin
                w_erros_rodada_prox = '0;
                w_carga = 1'b1;
            end
            if (bus.fim_jogo) begin
                w_estado_prox = ENCERRADO;
                w_carga = 1'b1;
`ifdef PONTOS_BONUS_EN
                if (!w_erros_jogo_prox) w_pontos_prox = 7'(w_sat_b);
`endif
            end
        end
    end

    bin2bcd_seq u_bcd (
        .clock (clock),
        .reset (reset),
        .carga (w_carga),
        .bin   (w_pontos_prox),
        .bcd   (w_bcd),
        .valido(w_valido)
    );

    assign bus.pontos = r_pontos;
    assign bus.display = w_bcd;
    assign bus.display_valido = w_valido;
    assign bus.db_estado = r_estado;
endmodule

// File: tb/tb_pontuacao_bcd.sv
// tb_pontuacao_bcd: scenario tasks plus randomized run against a decimal-arithmetic score model.
module tb_pontuacao_bcd;
    import pontuacao_pkg::*;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
`ifdef PONTOS_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif
    localparam int GB = GANHO_BASE_DEF;
    localparam int BF = BONUS_FINAL_DEF;
    localparam int MX = PONTOS_MAX_DEF;

    pontuacao_bcd_if bus ();
    pontuacao_bcd_if bus10 ();
    pontuacao_bcd dut (.clock(clock), .reset(rst_n), .bus(bus));
    pontuacao_bcd #(.GANHO_BASE(10)) dut10 (.clock(clock), .reset(rst_n), .bus(bus10));

    always #5 clock = ~clock;

    int m_st = 0, m_p = 0, m_er = 0, m_ej = 0, m_disp = 0, m_left = 0, m_tgt = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [11:0] bcd(input int v);
        logic [3:0] c, d, u;
        c = 4'(v / 100);
        d = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {c, d, u};
    endfunction

    function automatic logic [21:0] obs();
        return {bus.pontos, bus.display, bus.display_valido, bus.db_estado};
    endfunction

    function automatic logic [21:0] expv();
        return {7'(m_p), bcd(m_disp), m_left == 0, 2'(m_st)};
    endfunction

    // Drive one cycle of strobes, advance one edge, and evolve the model by the scoring rules.
    task automatic tick(input bit ini, input bit er, input bit fr, input bit fj);
        bit carga;
        bus.inicia = ini; bus.erro_jogada = er; bus.fim_rodada = fr; bus.fim_jogo = fj;
        @(posedge clock); #1;
        carga = 0;
        if (!rst_n) begin
            m_st = 0; m_p = 0; m_er = 0; m_ej = 0; m_disp = 0; m_left = 0; m_tgt = 0;
        end else begin
            if (ini) begin
                m_st = 1; m_p = 0; m_er = 0; m_ej = 0; carga = 1;
            end else if (m_st == 1) begin
                if (er) begin m_er = imin(m_er + 1, 7); m_ej = 1; end
                if (fr) begin m_p = imin(m_p + GB - imin(m_er, GB), MX); m_er = 0; carga = 1; end
                if (fj) begin
                    m_st = 2; carga = 1;
                    if (BONUS && m_ej == 0) m_p = imin(m_p + BF, MX);
                end
            end
            if (carga) begin
                m_left = 7; m_tgt = m_p;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_tgt;
            end
        end
        bus.inicia = 0; bus.erro_jogada = 0; bus.fim_rodada = 0; bus.fim_jogo = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        checks++;
        if (obs() !== {7'd0, 12'h000, 1'b1, 2'd0}) begin
            errors++; $display("FAIL reset obs=%h exp=%h", obs(), {7'd0, 12'h000, 1'b1, 2'd0});
        end
        rst_n = 1;
        tick(0, 0, 0, 0);
    endtask

    task automatic test_rodadas_limpas();
        tick(1, 0, 0, 0);
        for (int r = 0; r < 16; r++) begin tick(0, 0, 1, 0); tick(0, 0, 0, 0); end
        repeat (8) tick(0, 0, 0, 0);
        checks++;
        if (bus.pontos !== 7'd80 || bus.display !== 12'h080) begin
            errors++; $display("FAIL rodadas80 pontos=%0d disp=%h exp 80/080", bus.pontos, bus.display);
        end
        tick(0, 0, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL fim_jogo_c%0d obs=%h exp=%h", c, obs(), expv());
            end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (bus.display !== (BONUS ? 12'h100 : 12'h080) || bus.db_estado !== 2'd2) begin
            errors++; $display("FAIL bonus disp=%h st=%0d", bus.display, bus.db_estado);
        end
    endtask

    task automatic test_erros();
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 1, 0);
        checks++;
        if (bus.pontos !== 7'd3) begin errors++; $display("FAIL erros2 pontos=%0d exp=3", bus.pontos); end
        tick(0, 1, 0, 0); tick(0, 1, 1, 0);
        checks++;
        if (bus.pontos !== 7'd6) begin errors++; $display("FAIL erro_coincide pontos=%0d exp=6", bus.pontos); end
        repeat (8) tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        checks++;
        if (bus.pontos !== 7'd6) begin errors++; $display("FAIL erros9 pontos=%0d exp=6", bus.pontos); end
        tick(0, 0, 1, 0);
        checks++;
        if (bus.pontos !== 7'd11) begin errors++; $display("FAIL contador_limpo pontos=%0d exp=11", bus.pontos); end
        tick(0, 0, 0, 1); tick(0, 1, 1, 0);
        checks++;
        if (bus.pontos !== 7'd11 || bus.db_estado !== 2'd2) begin
            errors++; $display("FAIL sem_bonus pontos=%0d st=%0d exp 11/2", bus.pontos, bus.db_estado);
        end
        repeat (8) tick(0, 0, 0, 0);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL erros_fim obs=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_reinicio_conversao();
        tick(1, 0, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL reinicio_c%0d obs=%h exp=%h", c, obs(), expv()); end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (bus.display !== 12'h010 || bus.display_valido !== 1'b1) begin
            errors++; $display("FAIL reinicio_final disp=%h v=%b exp 010/1", bus.display, bus.display_valido);
        end
    endtask

    task automatic test_reset_meio();
        tick(1, 0, 0, 0);
        repeat (8) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        rst_n = 0;
        tick(0, 0, 0, 0);
        checks++;
        if (obs() !== {7'd0, 12'h000, 1'b1, 2'd0}) begin
            errors++; $display("FAIL reset_meio obs=%h exp=%h", obs(), {7'd0, 12'h000, 1'b1, 2'd0});
        end
        rst_n = 1;
        tick(0, 1, 1, 0); tick(0, 0, 1, 1); tick(0, 0, 0, 0);
        checks++;
        if (obs() !== {7'd0, 12'h000, 1'b1, 2'd0}) begin
            errors++; $display("FAIL ocioso_ignora obs=%h exp=%h", obs(), {7'd0, 12'h000, 1'b1, 2'd0});
        end
    endtask

    task automatic test_inicia_coincidente();
        tick(1, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin tick(0, 0, 1, 0); tick(0, 0, 0, 0); end
        checks++;
        if (bus.pontos !== 7'd40) begin errors++; $display("FAIL pontos40 pontos=%0d exp=40", bus.pontos); end
        repeat (8) tick(0, 0, 0, 0);
        tick(1, 0, 1, 0);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL inicia_c%0d obs=%h exp=%h", c, obs(), expv()); end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (obs() !== {7'd0, 12'h000, 1'b1, 2'd1}) begin
            errors++; $display("FAIL inicia_final obs=%h exp=%h", obs(), {7'd0, 12'h000, 1'b1, 2'd1});
        end
    endtask

    task automatic test_aleatorio();
        tick(1, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
            rst_n = 1;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL aleatorio_c%0d obs=%h exp=%h", c, obs(), expv()); end
        end
    endtask

    task automatic test_ganho10();
        bus10.inicia = 1; tick(0, 0, 0, 0); bus10.inicia = 0;
        for (int r = 1; r <= 12; r++) begin
            bus10.fim_rodada = 1; tick(0, 0, 0, 0); bus10.fim_rodada = 0;
            checks++;
            if (bus10.pontos !== 7'(imin(10 * r, 100))) begin
                errors++; $display("FAIL ganho10_r%0d pontos=%0d exp=%0d", r, bus10.pontos, imin(10 * r, 100));
            end
        end
        repeat (8) tick(0, 0, 0, 0);
        checks++;
        if (bus10.display !== 12'h100 || bus10.display_valido !== 1'b1) begin
            errors++; $display("FAIL ganho10_disp disp=%h v=%b exp 100/1", bus10.display, bus10.display_valido);
        end
    endtask

    initial begin
        bus.inicia = 0; bus.erro_jogada = 0; bus.fim_rodada = 0; bus.fim_jogo = 0;
        bus10.inicia = 0; bus10.erro_jogada = 0; bus10.fim_rodada = 0; bus10.fim_jogo = 0;
        test_reset();
        test_rodadas_limpas();
        test_erros();
        test_reinicio_conversao();
        test_reset_meio();
        test_inicia_coincidente();
        test_ganho10();
        test_aleatorio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pontuacao_bcd.md
# pontuacao_bcd

Score unit downstream of the game control/datapath in `circuito_S1`. It consumes per-round outcome strobes (plays, errors, round end, game end) and accumulates a saturating 0..100 score with an optional end-of-game bonus. It converts the score to three BCD digits for the `display[11:0]` output with a sequential double-dabble converter, so the score logic needs no combinational divider.

## Interface
- `GANHO_BASE`, 5: points awarded for an error-free round.
- `BONUS_FINAL`, 20: points added at game end if the whole game had zero errors.
- `PONTOS_MAX`, 100: saturation ceiling. Must be ≤ 127.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low. `0` at a rising edge resets the block.
- `inicia`  in  1: one-cycle pulse that starts a new game and clears the score.
- `erro_jogada`  in  1: one-cycle pulse, one wrong play in the current round.
- `fim_rodada`  in  1: one-cycle pulse, current round finished.
- `fim_jogo`  in  1: one-cycle pulse, game finished.
- `pontos`  out  7: binary score.
- `display`  out  12: BCD score. `[11:8]` hundreds, `[7:4]` tens, `[3:0]` units.
- `display_valido`  out  1: `display` matches `pontos`.
- `db_estado`  out  2: score FSM state code.

## Operation
- Score FSM states:
  - `OCIOSO` = 0. Entered at reset. All inputs except `inicia` are ignored.
  - `JOGANDO` = 1.
  - `ENCERRADO` = 2. Only `inicia` is accepted.
- Transitions:
  - `inicia` → `JOGANDO` from any state.
  - `fim_jogo` in `JOGANDO` → `ENCERRADO`.
- Counters:
  - `erros_rodada`: 3 bits, saturates at 7, cleared by `inicia` and by `fim_rodada`.
  - `erros_jogo`: 1 bit, a flag set by any accepted `erro_jogada`, cleared by `inicia`.
- `inicia`: `pontos` ← 0 and both counters cleared.
- `fim_rodada` in `JOGANDO`: ganho = `GANHO_BASE` − min(`erros_rodada`, `GANHO_BASE`). `pontos` ← min(`pontos` + ganho, `PONTOS_MAX`), computed in 8 bits.
- `fim_jogo` in `JOGANDO`: if `erros_jogo` = 0, `pontos` ← min(`pontos` + `BONUS_FINAL`, `PONTOS_MAX`).
- Simultaneous events, in priority order:
  - `inicia` overrides all other inputs in the same cycle.
  - `erro_jogada` together with `fim_rodada`: the error counts toward the ending round before the gain is computed. The error also sets `erros_jogo`.
  - `fim_rodada` together with `fim_jogo`: round gain is applied first, then the bonus, all in one update. The bonus test includes any error arriving in that cycle.
- BCD converter (`PARADO`/`CONVERTE`):
  - Every accepted `inicia`/`fim_rodada`/`fim_jogo` loads the next `pontos` value into the converter, even if the value is unchanged.
  - A load while in `CONVERTE` aborts the current conversion and restarts it.
  - Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left by 1. 7 iterations are performed.
- Reset values:
  - `pontos` = 0, `display` = 12'h000, `display_valido` = 1.
  - `db_estado` = 0 (`OCIOSO`), converter in `PARADO`, counters 0.
- Reset mid-conversion aborts the conversion; all reset values apply at the next edge.

## Timing
- An event sampled at edge N updates `pontos` after edge N.
- `display_valido` drops to 0 after edge N. The shift iterations occur on edges N+1 through N+7.
- `display` updates atomically, and `display_valido` returns to 1, after edge N+7. Latency is 7 cycles from `pontos`.
- `display` holds its old value throughout a conversion, never a partial value.
- Inputs are level-sampled. A pulse held for k cycles counts as k events, so upstream must deliver single-cycle strobes.

## Configuration
- `PONTOS_BONUS_EN`:
  - Defined: the end-of-game bonus is applied as described above.
  - Undefined: `fim_jogo` only moves the FSM to `ENCERRADO` and triggers a reload. `pontos` is unchanged, and `erros_jogo` and the bonus logic are removed.

## Structure
- Package `pontuacao_pkg`:
  - score-FSM state enum with the codes 0/1/2;
  - converter state enum;
  - width constants (`W_PONTOS` = 7, `W_BCD` = 12, `W_ERROS` = 3);
  - default parameter values.
- Sub-module `bin2bcd_seq`:
  - sequential double-dabble converter;
  - inputs `carga` and `bin[6:0]`;
  - outputs `bcd[11:0]` and `valido`;
  - same `clock`/`reset`.
- Top level holds the score FSM, counters and saturating adder.

## Test plan
- 16 error-free rounds, then `fim_jogo` → `pontos` = 80 before `fim_jogo`, then 100; `display` = 12'h100, `display_valido` = 1 exactly 7 cycles after `pontos` changes.
- Round with 2 `erro_jogada`, then `fim_rodada` → `pontos` +3. Later a round with 9 errors → gain 0, counter at 7. `fim_jogo` adds no bonus.
- `GANHO_BASE` = 10, 12 error-free rounds → `pontos` saturates at 100 from round 10 on. No wrap.
- `fim_rodada` 3 cycles into a conversion → restart. Final `display` matches the new `pontos`; no intermediate value is ever visible.
- `reset` = 0 mid-conversion, and `fim_rodada`/`erro_jogada` in `OCIOSO` → all outputs at reset values; events ignored; `db_estado` = 0.
- `inicia` coincident with `fim_rodada` in `JOGANDO` with `pontos` = 40 → `pontos` = 0, `display` = 12'h000 after 7 cycles.
